// File: rtl/pressure_mon_pkg.sv
// ============================================================================
// Module : pressure_mon_pkg
// Brief  : Shared state encoding, alarm codes and sample classification.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pressure_mon_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_LOW  = 2'b01;
  localparam logic [1:0] CODE_HIGH = 2'b10;

  function automatic logic [1:0] classifySample(input logic [31:0] sample,
                                                input logic [31:0] lowTh,
                                                input logic [31:0] highTh);
    if (sample < lowTh)       return CODE_LOW;
    else if (sample > highTh) return CODE_HIGH;
    else                      return CODE_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pressure_window_classifier.sv
// ============================================================================
// Module : pressure_window_classifier
// Brief  : Combinational unsigned window compare of one pressure sample.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pressure_window_classifier
  import pressure_mon_pkg::*;
#(
  parameter int DATA_W  = 6,
  parameter int LOW_TH  = 12,
  parameter int HIGH_TH = 40
) (
  input  logic [DATA_W-1:0] pressureData,
  output logic              isLow,
  output logic              isHigh
);

  // Limits are taken at sample width so the compare stays unsigned at DATA_W.
  localparam logic [DATA_W-1:0] c_lowTh  = DATA_W'(LOW_TH);
  localparam logic [DATA_W-1:0] c_highTh = DATA_W'(HIGH_TH);

  logic [1:0] w_class;

  assign w_class = classifySample(32'(pressureData), 32'(c_lowTh), 32'(c_highTh));
  assign isLow   = (w_class == CODE_LOW);
  assign isHigh  = (w_class == CODE_HIGH);

endmodule

`default_nettype wire

// File: rtl/pressure_abnormality_monitor.sv
// ============================================================================
// Module : pressure_abnormality_monitor
// Brief  : Debounced pressure window alarm (raise after PERSIST abnormal,
//          clear after CLEAR_CNT normal samples). Optional latched alarm with
//          operator acknowledge when PRESSURE_ALARM_LATCH_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pressure_abnormality_monitor
  import pressure_mon_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int LOW_TH    = 12,
  parameter int HIGH_TH   = 40,
  parameter int PERSIST   = 4,
  parameter int CLEAR_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sampleValid,
  input  logic [DATA_W-1:0] pressureData,
  input  logic              alarmAck,
  output logic              pressureAbnormality,
  output logic              alarm,
  output logic [1:0]        alarmCode,
  output logic [1:0]        state
);

`ifdef PRESSURE_ALARM_LATCH_EN
  localparam bit c_latchEn = 1'b1;
`else
  localparam bit c_latchEn = 1'b0;
`endif

  localparam int c_maxCnt = (PERSIST > CLEAR_CNT) ? PERSIST : CLEAR_CNT;
  localparam int c_cntW   = $clog2(c_maxCnt + 1);
  localparam logic [c_cntW-1:0] c_one       = c_cntW'(1);
  localparam logic [c_cntW-1:0] c_persistM1 = c_cntW'(PERSIST - 1);
  localparam logic [c_cntW-1:0] c_clearM1   = c_cntW'(CLEAR_CNT - 1);

  logic              w_isLow;
  logic              w_isHigh;
  logic              w_abn;
  logic [1:0]        w_kind;
  logic [c_cntW-1:0] w_cntInc;

  state_t            r_state;
  logic [c_cntW-1:0] r_cnt;
  logic [1:0]        r_kind;
  logic              r_abn;
  logic              r_alarm;
  logic [1:0]        r_code;

  pressure_window_classifier #(
    .DATA_W (DATA_W),
    .LOW_TH (LOW_TH),
    .HIGH_TH(HIGH_TH)
  ) u_classifier (
    .pressureData(pressureData),
    .isLow       (w_isLow),
    .isHigh      (w_isHigh)
  );

  assign w_abn    = w_isLow | w_isHigh;
  assign w_kind   = w_isLow ? CODE_LOW : (w_isHigh ? CODE_HIGH : CODE_NONE);
  assign w_cntInc = (r_cnt == {c_cntW{1'b1}}) ? r_cnt : r_cnt + c_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
      r_kind  <= CODE_NONE;
      r_abn   <= 1'b0;
      r_alarm <= 1'b0;
      r_code  <= CODE_NONE;
    end else begin
      // Acknowledge acts before the sample update so a same-cycle alarm entry wins.
      if (c_latchEn && alarmAck && (r_state == NORMAL || r_state == PENDING)) begin
        r_alarm <= 1'b0;
        r_code  <= CODE_NONE;
      end
      if (sampleValid) begin
        r_abn <= w_abn;
        unique case (r_state)
          NORMAL: begin
            if (w_abn) begin
              r_kind <= w_kind;
              if (PERSIST == 1) begin
                r_state <= ALARM;
                r_cnt   <= '0;
                r_alarm <= 1'b1;
                r_code  <= w_kind;
              end else begin
                r_state <= PENDING;
                r_cnt   <= c_one;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          PENDING: begin
            if (!w_abn) begin
              r_state <= NORMAL;
              r_cnt   <= '0;
              r_kind  <= CODE_NONE;
            end else if (w_kind != r_kind) begin
              r_cnt  <= c_one;
              r_kind <= w_kind;
            end else if (r_cnt >= c_persistM1) begin
              r_state <= ALARM;
              r_cnt   <= '0;
              r_alarm <= 1'b1;
              r_code  <= r_kind;
            end else begin
              r_cnt <= w_cntInc;
            end
          end
          ALARM: begin
            if (w_abn) begin
              r_kind <= w_kind;
              r_code <= w_kind;
            end else if (CLEAR_CNT == 1) begin
              r_state <= NORMAL;
              r_cnt   <= '0;
              r_kind  <= CODE_NONE;
              if (!c_latchEn) begin
                r_alarm <= 1'b0;
                r_code  <= CODE_NONE;
              end
            end else begin
              r_state <= RECOVER;
              r_cnt   <= c_one;
            end
          end
          RECOVER: begin
            if (w_abn) begin
              r_state <= ALARM;
              r_cnt   <= '0;
              r_kind  <= w_kind;
              r_code  <= w_kind;
            end else if (r_cnt >= c_clearM1) begin
              r_state <= NORMAL;
              r_cnt   <= '0;
              r_kind  <= CODE_NONE;
              if (!c_latchEn) begin
                r_alarm <= 1'b0;
                r_code  <= CODE_NONE;
              end
            end else begin
              r_cnt <= w_cntInc;
            end
          end
          default: r_state <= NORMAL;
        endcase
      end
    end
  end

  assign pressureAbnormality = r_abn;
  assign alarm               = r_alarm;
  assign alarmCode           = r_code;
  assign state               = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pressure_abnormality_monitor.sv
// ============================================================================
// Module : tb_pressure_abnormality_monitor
// Brief  : Scoreboard bench for pressure_abnormality_monitor (default limits);
//          expectations adapt when PRESSURE_ALARM_LATCH_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pressure_abnormality_monitor;

`ifdef PRESSURE_ALARM_LATCH_EN
  localparam bit c_latch = 1'b1;
`else
  localparam bit c_latch = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sampleValid;
  logic [5:0] pressureData;
  logic       alarmAck;
  logic       pressureAbnormality;
  logic       alarm;
  logic [1:0] alarmCode;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       abn;
    logic       alm;
    logic [1:0] code;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  pressure_abnormality_monitor u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sampleValid        (sampleValid),
    .pressureData       (pressureData),
    .alarmAck           (alarmAck),
    .pressureAbnormality(pressureAbnormality),
    .alarm              (alarm),
    .alarmCode          (alarmCode),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, then score it after the edge.
  task automatic step(input string tag, input logic v, input logic [5:0] d, input logic a,
                      input logic eAbn, input logic eAlm, input logic [1:0] eCode,
                      input logic [1:0] eSt);
    exp_t e;
    @(negedge clk);
    sampleValid  = v;
    pressureData = d;
    alarmAck     = a;
    sb.push_back('{tag, eAbn, eAlm, eCode, eSt});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checkVal({e.tag, ".abn"},   8'(pressureAbnormality), 8'(e.abn));
      checkVal({e.tag, ".alarm"}, 8'(alarm),               8'(e.alm));
      checkVal({e.tag, ".code"},  8'(alarmCode),           8'(e.code));
      checkVal({e.tag, ".state"}, 8'(state),               8'(e.st));
    end
    sampleValid = 1'b0;
    alarmAck    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sampleValid  = 1'b0;
    pressureData = '0;
    alarmAck     = 1'b0;
    #23;
    checkVal("rst.abn",   8'(pressureAbnormality), 8'd0);
    checkVal("rst.alarm", 8'(alarm),               8'd0);
    checkVal("rst.code",  8'(alarmCode),           8'd0);
    checkVal("rst.state", 8'(state),               8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Classification and kind restart
    step("n40",  1'b1, 6'd40, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("h44",  1'b1, 6'd44, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    step("l0",   1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    step("n12",  1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // Raise HIGH alarm; the 4-sample count must start fresh after n12
    for (int i = 0; i < 3; i++)
      step($sformatf("h44_%0d", i), 1'b1, 6'd44, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    step("h44_3",  1'b1, 6'd44, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2);
    step("ackAlm", 1'b0, 6'd44, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2);

    // Recover to NORMAL
    step("r20_0", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    step("r20_1", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    step("r20_2", 1'b1, 6'd20, 1'b0, 1'b0, c_latch, c_latch ? 2'd2 : 2'd0, 2'd0);
    step("ackNrm1", 1'b0, 6'd20, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

    // All-ones sample raises HIGH; recovery aborted by 50
    for (int i = 0; i < 3; i++)
      step($sformatf("h63_%0d", i), 1'b1, 6'd63, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    step("h63_3", 1'b1, 6'd63, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2);
    step("v20_0", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    step("v20_1", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    step("v50",   1'b1, 6'd50, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2);
    step("k5",    1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 2'd1, 2'd2);
    step("c20_0", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
    step("c20_1", 1'b1, 6'd20, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
    step("c20_2", 1'b1, 6'd20, 1'b0, 1'b0, c_latch, c_latch ? 2'd1 : 2'd0, 2'd0);
    step("ackNrm2", 1'b0, 6'd20, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

    // LOW alarm with idle cycles between valid samples (idle data would restart the count)
    for (int i = 0; i < 4; i++) begin
      step($sformatf("l5_%0d", i), 1'b1, 6'd5, 1'b0, 1'b1, (i == 3),
           (i == 3) ? 2'd1 : 2'd0, (i == 3) ? 2'd2 : 2'd1);
      if (i < 3)
        step($sformatf("idle_%0d", i), 1'b0, 6'd44, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    end

    // Asynchronous reset between edges while in ALARM
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("arst.abn",   8'(pressureAbnormality), 8'd0);
    checkVal("arst.alarm", 8'(alarm),               8'd0);
    checkVal("arst.code",  8'(alarmCode),           8'd0);
    checkVal("arst.state", 8'(state),               8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Upper boundary: 41 abnormal, 40 normal
    step("h41", 1'b1, 6'd41, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
    step("n40b", 1'b1, 6'd40, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("l11", 1'b1, 6'd11, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pressure_abnormality_monitor.md
Name: pressure_abnormality_monitor

Overview:
Sampled, parametrised successor to the combinational pressure abnormality detector. Classifies each valid pressure sample against a configurable normal window (low and high limits). Raises a debounced alarm only after PERSIST consecutive abnormal samples, and clears it after CLEAR_CNT consecutive normal samples. Sits between the pressure sensor sampling path and the health-care system alarm/display logic.

Parameters:
DATA_W, 6, pressure sample width in bits.
LOW_TH, 12, lowest normal value, inclusive; sample < LOW_TH is LOW abnormal.
HIGH_TH, 40, highest normal value, inclusive; sample > HIGH_TH is HIGH abnormal.
PERSIST, 4, consecutive abnormal valid samples required to raise the alarm (>=1).
CLEAR_CNT, 3, consecutive normal valid samples required to clear the alarm (>=1).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
sampleValid  in  1  pressureData is a new sample this cycle.
pressureData  in  DATA_W  unsigned pressure sample.
alarmAck  in  1  operator acknowledge; used only with the optional feature.
pressureAbnormality  out  1  registered raw flag: last valid sample was outside the window.
alarm  out  1  debounced alarm.
alarmCode  out  2  00 none, 01 LOW, 10 HIGH; 11 never driven.
state  out  2  FSM state, for debug and display.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, state=NORMAL, counters 0, stored kind=none.
- Classification is combinational on pressureData:
  - LOW if pressureData < LOW_TH.
  - HIGH if pressureData > HIGH_TH.
  - Otherwise normal.
  - Compare is unsigned at DATA_W.
- Update rule:
  - Only cycles with sampleValid=1 advance state and counters.
  - With sampleValid=0, everything holds.
  - pressureAbnormality updates 1 cycle after the valid sample.
- FSM (state encoding 0..3):
  - NORMAL:
    - On an abnormal sample: cnt=1, store kind.
    - If PERSIST==1, go directly to ALARM; otherwise go to PENDING.
  - PENDING:
    - Abnormal sample of the same kind: cnt+1. When cnt reaches PERSIST, go to ALARM.
    - Abnormal sample of the other kind: restart with cnt=1 and the new kind.
    - Normal sample: go to NORMAL, cnt=0.
  - ALARM:
    - alarm=1 and alarmCode=kind, both registered, asserted the cycle after the PERSIST-th sample.
    - Abnormal sample of either kind: stay in ALARM; alarmCode follows the latest kind.
    - Normal sample: go to RECOVER with cnt=1. If CLEAR_CNT==1, go directly to NORMAL.
  - RECOVER:
    - alarm stays 1.
    - Normal sample: cnt+1. When cnt reaches CLEAR_CNT, go to NORMAL; alarm=0 and alarmCode=00 on the next edge.
    - Abnormal sample: back to ALARM, cnt=0, alarmCode=kind.
- Counter: width $clog2(max(PERSIST,CLEAR_CNT)+1). It saturates and never wraps.
- Boundaries:
  - pressureData==LOW_TH and pressureData==HIGH_TH are normal.
  - All-ones and zero inputs are legal samples.
- Reset asserted mid-episode clears everything immediately. There is no recovery of prior state.
- Without the optional feature, alarmAck is ignored.

Optional Feature:
- Macro: PRESSURE_ALARM_LATCH_EN.
- Defined:
  - On the RECOVER to NORMAL transition, alarm and alarmCode stay latched.
  - They clear on the first clk edge with alarmAck=1 while the FSM is in NORMAL or PENDING.
  - alarmAck while in ALARM or RECOVER is ignored.
  - A new ALARM entry overwrites alarmCode.
- Undefined: alarm clears automatically as described in Behaviour; alarmAck is unused.

Decomposition:
- Package pressure_mon_pkg holds:
  - State enum: NORMAL=0, PENDING=1, ALARM=2, RECOVER=3.
  - Alarm code constants: CODE_NONE, CODE_LOW, CODE_HIGH.
  - A function returning the class of a sample given the limits.
- One sub-module, pressure_window_classifier: combinational compare producing isLow/isHigh, parametrised by DATA_W, LOW_TH and HIGH_TH.
- The FSM and counter live in the top module.

Test Plan:
- Defaults; samples 40, 44, 0 (one each) -> pressureAbnormality 0, 1, 1; alarm stays 0; state 0 then 1 then 1 with cnt restarted to 1 for LOW.
- Four valid samples of 44 -> alarm=1, alarmCode=10 one cycle after the 4th; state=2.
- From ALARM: three samples of 20 -> state 3, 3, then NORMAL; alarm=0 after the 3rd. Variant: 20, 20, 50 -> back to ALARM with alarmCode=10.
- Interleave sampleValid=0 cycles between four samples of 5 -> counter holds on idle cycles; alarm and alarmCode=01 after the 4th valid sample.
- Assert rst_n=0 asynchronously mid-ALARM, between clock edges -> all outputs 0 immediately; state=0.
- With PRESSURE_ALARM_LATCH_EN: alarm, then three samples of 20 -> alarm stays 1. Pulse alarmAck -> alarm=0 and alarmCode=00 on the next edge. alarmAck pulsed during ALARM -> no effect.
